posit_display_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit posit-to-BCD display converter (decompose → radix split → double-dabble path) among NREQ requesters. It accepts posits over per-requester valid/ready handshakes and drives the converter's posit input and reset. It waits a fixed conversion time, captures the whole/fraction BCD result, and returns it with the requester ID over a valid/ready response port. Zero and NaR bypass the converter.

---
 rtl/posit_display_arbiter.sv | 138 +++++++++++++
 tb/tb_posit_display_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/posit_display_arbiter.sv
// Round-robin sequencer sharing one posit-to-BCD converter among NREQ requesters.
// Zero and NaR are answered directly; other posits wait out a fixed conversion window.
module posit_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int NBITS       = 16,
  parameter int CONV_CYCLES = 72
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*NBITS-1:0]    req_posit,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     resp_sign,
  output logic                     resp_nar,
  output logic [39:0]              resp_whole_bcd,
  output logic [39:0]              resp_frac_bcd,
  output logic [NBITS-1:0]         conv_posit,
  output logic                     conv_reset,
  input  logic [39:0]              conv_whole_bcd,
  input  logic [39:0]              conv_frac_bcd
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(CONV_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_posit;
  logic [IDW-1:0]   r_id;
  logic             r_sign;
  logic             r_nar;
  logic [39:0]      r_whole;
  logic [39:0]      r_frac;

  logic             w_any;
  logic [IDW-1:0]   w_grant;
  logic [IDW-1:0]   w_gidx;
  int unsigned      w_idx;
  logic [IDW-1:0]   w_next_ptr;
  logic [NBITS-1:0] w_req_posit;

  // Scan requesters in circular order starting at r_rr_ptr; first valid wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    w_gidx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_gidx = IDW'(w_idx);
      if (!w_any && req_valid[w_gidx]) begin
        w_any   = 1'b1;
        w_grant = w_gidx;
      end
    end
  end

  assign w_req_posit = req_posit[w_grant*NBITS +: NBITS];
  assign w_next_ptr  = (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && !reset && w_any) req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_posit  <= '0;
      r_id     <= '0;
      r_sign   <= 1'b0;
      r_nar    <= 1'b0;
      r_whole  <= '0;
      r_frac   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_posit <= w_req_posit;
            r_id    <= w_grant;
            r_sign  <= w_req_posit[NBITS-1];
            r_nar   <= 1'b0;
            if (w_req_posit == '0) begin
              r_whole <= '0;
              r_frac  <= '0;
              r_state <= S_HOLD;
            end else if (w_req_posit == {1'b1, {(NBITS-1){1'b0}}}) begin
              r_whole <= '0;
              r_frac  <= '0;
              r_nar   <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(CONV_CYCLES-1)) begin
            r_whole <= conv_whole_bcd;
            r_frac  <= conv_frac_bcd;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (resp_ready) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid     = (r_state == S_HOLD);
  assign resp_id        = r_id;
  assign resp_sign      = r_sign;
  assign resp_nar       = r_nar;
  assign resp_whole_bcd = r_whole;
  assign resp_frac_bcd  = r_frac;
  assign conv_posit     = r_posit;
  assign conv_reset     = reset | (r_state == S_LOAD);

endmodule

// File: tb/tb_posit_display_arbiter.sv
// Bench for posit_display_arbiter: converter model with a settle window, directed
// scenarios followed by randomized rounds against a circular-priority reference.
module tb_posit_display_arbiter;

  localparam int NREQ = 4;
  localparam int NB   = 16;
  localparam int CC   = 72;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req_valid = '0;
  logic [63:0]    req_posit = '0;
  logic [3:0]     req_ready;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [1:0]     resp_id;
  logic           resp_sign;
  logic           resp_nar;
  logic [39:0]    resp_whole_bcd;
  logic [39:0]    resp_frac_bcd;
  logic [15:0]    conv_posit;
  logic           conv_reset;
  logic [39:0]    conv_whole_bcd;
  logic [39:0]    conv_frac_bcd;

  int n_err = 0;
  int n_chk = 0;
  int mcnt  = 0;
  logic [15:0] tbpos [4];

  posit_display_arbiter #(.NREQ(NREQ), .NBITS(NB), .CONV_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_posit(req_posit),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sign(resp_sign), .resp_nar(resp_nar),
    .resp_whole_bcd(resp_whole_bcd), .resp_frac_bcd(resp_frac_bcd),
    .conv_posit(conv_posit), .conv_reset(conv_reset),
    .conv_whole_bcd(conv_whole_bcd), .conv_frac_bcd(conv_frac_bcd)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] m_whole(input logic [15:0] p);
    case (p)
      16'h4000: return 40'h1;
      16'h5000: return 40'h2;
      16'hC000: return 40'h1;
      default:  return {24'h0, p};
    endcase
  endfunction

  function automatic logic [39:0] m_frac(input logic [15:0] p);
    return {p ^ 16'h5A5A, 8'h00, p};
  endfunction

  // Converter model: outputs are garbage until CC-1 cycles after reset release.
  always @(posedge clock) begin
    if (conv_reset) mcnt <= 0;
    else if (mcnt < 10000) mcnt <= mcnt + 1;
  end
  assign conv_whole_bcd = (!conv_reset && mcnt >= CC-1) ? m_whole(conv_posit) : 40'hEEEEEEEEEE;
  assign conv_frac_bcd  = (!conv_reset && mcnt >= CC-1) ? m_frac(conv_posit)  : 40'hDDDDDDDDDD;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] p);
    req_valid[i] = 1'b1;
    req_posit[i*16 +: 16] = p;
    tbpos[i] = p;
  endtask

  // One transaction: grant check, latency, converter reset pulse, response fields,
  // optional backpressure, and single-cycle resp_valid after the handshake.
  task automatic txn(input int id, input logic [15:0] p, input int bp,
                     input logic [3:0] drop_mask, output time t_resp);
    int t, lat, pulses, pulse_lat;
    bit byp, pos_ok, stable_ok;
    logic [39:0] sw, sf;
    logic [1:0] sid;
    logic ss, sn;
    byp = (p == 16'h0000) || (p == 16'h8000);
    resp_ready = (bp == 0);
    #1;
    t = 0;
    while (req_ready == 4'b0 && t < 20) begin
      @(negedge clock); #1; t++;
    end
    check($sformatf("grant_r%0d", id), req_ready, 64'(4'b1 << id));
    @(negedge clock);
    req_valid = req_valid & ~drop_mask;
    lat = 1; pulses = 0; pulse_lat = 0; pos_ok = 1;
    while (!resp_valid && lat < 300) begin
      if (conv_reset) begin pulses++; pulse_lat = lat; end
      if (conv_posit !== p) pos_ok = 0;
      @(negedge clock); lat++;
    end
    t_resp = $time;
    check($sformatf("latency_r%0d", id), lat, byp ? 1 : CC + 2);
    if (byp) begin
      check("conv_reset_pulses_bypass", pulses, 0);
    end else begin
      check("conv_reset_pulses", pulses, 1);
      check("conv_reset_at_T1", pulse_lat, 1);
      check("conv_posit_stable", pos_ok, 1);
    end
    check("resp_id", resp_id, id);
    check("resp_sign", resp_sign, p[15]);
    check("resp_nar", resp_nar, p == 16'h8000);
    check("resp_whole", resp_whole_bcd, byp ? 40'h0 : m_whole(p));
    check("resp_frac", resp_frac_bcd, byp ? 40'h0 : m_frac(p));
    if (bp > 0) begin
      sw = resp_whole_bcd; sf = resp_frac_bcd; sid = resp_id; ss = resp_sign; sn = resp_nar;
      stable_ok = 1;
      repeat (bp) begin
        @(negedge clock);
        if (!resp_valid || req_ready != 4'b0 || resp_whole_bcd !== sw || resp_frac_bcd !== sf
            || resp_id !== sid || resp_sign !== ss || resp_nar !== sn || conv_posit !== p)
          stable_ok = 0;
      end
      check("backpressure_hold", stable_ok, 1);
      resp_ready = 1'b1;
    end
    @(negedge clock);
    check("resp_valid_one_cycle", resp_valid, 0);
  endtask

  time ts [5];
  time tdummy;
  int  m_rr;
  int  q [$];
  int  eid;
  int  r;
  bit  ok;
  logic [15:0] rp;

  initial begin
    reset = 1'b1;
    req_valid = 4'hF;
    req_posit = {4{16'h4000}};
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_sign", resp_sign, 0);
    check("rst_resp_nar", resp_nar, 0);
    check("rst_whole", resp_whole_bcd, 0);
    check("rst_frac", resp_frac_bcd, 0);
    check("rst_conv_posit", conv_posit, 0);
    check("rst_conv_reset", conv_reset, 1);
    req_valid = '0;
    reset = 1'b0;
    @(negedge clock);
    check("idle_conv_reset", conv_reset, 0);

    // Fairness: all four held valid with 2.0 -> 0,1,2,3,0 at 75-cycle spacing.
    for (int i = 0; i < 4; i++) set_req(i, 16'h5000);
    for (int k = 0; k < 5; k++)
      txn(k % 4, 16'h5000, 0, (k == 4) ? 4'hF : 4'h0, ts[k]);
    for (int k = 1; k < 5; k++)
      check($sformatf("spacing_%0d", k), ts[k] - ts[k-1], 64'(75 * 10));

    // Single normal request (rr_ptr now 1, only requester 0 pending).
    set_req(0, 16'h4000);
    txn(0, 16'h4000, 0, 4'b0001, tdummy);

    // Bypass zero then NaR.
    set_req(2, 16'h0000);
    txn(2, 16'h0000, 0, 4'b0100, tdummy);
    set_req(3, 16'h8000);
    txn(3, 16'h8000, 0, 4'b1000, tdummy);

    // Backpressure with a competing requester waiting.
    set_req(1, 16'h4800);
    set_req(3, 16'h1234);
    txn(1, 16'h4800, 20, 4'b0010, tdummy);
    txn(3, 16'h1234, 0, 4'b1000, tdummy);

    // Negative posit.
    set_req(2, 16'hC000);
    txn(2, 16'hC000, 0, 4'b0100, tdummy);

    // Move rr_ptr to 1, then abort a conversion with reset at counter 30.
    set_req(0, 16'h3000);
    txn(0, 16'h3000, 0, 4'b0001, tdummy);
    set_req(2, 16'h6000);
    #1;
    check("abort_grant", req_ready, 4'b0100);
    @(negedge clock);
    req_valid[2] = 1'b0;
    repeat (31) @(negedge clock);
    reset = 1'b1;
    set_req(0, 16'h4000);
    set_req(2, 16'h6000);
    ok = 1;
    repeat (3) begin
      @(negedge clock);
      if (!conv_reset || resp_valid || req_ready != 4'b0) ok = 0;
    end
    check("abort_during_reset", ok, 1);
    reset = 1'b0;
    txn(0, 16'h4000, 0, 4'b0001, tdummy);
    txn(2, 16'h6000, 0, 4'b0100, tdummy);

    // Randomized rounds against a circular-priority reference.
    m_rr = 3;
    for (int round = 0; round < 12; round++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          rp = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : 16'($urandom);
          set_req(i, rp);
        end
      end
      if (req_valid == 4'b0) set_req($urandom_range(0, 3), 16'($urandom));
      q.delete();
      for (int k = 0; k < 4; k++)
        if (req_valid[(m_rr + k) % 4]) q.push_back((m_rr + k) % 4);
      eid = q[0];
      txn(eid, tbpos[eid], $urandom_range(0, 3), 4'(1 << eid), tdummy);
      m_rr = (eid + 1) % 4;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
